// File: rtl/mips_cpu_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op encoding,
// sequencer states, iteration count and operand magnitude helper.
package mips_cpu_pkg;

    localparam int unsigned ITER_COUNT = 32;

    typedef enum logic [1:0] {
        OP_DIVU  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_MULT  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIX  = 2'b10
    } state_e;

    // Two's-complement magnitude; 0x80000000 maps to itself, which is the
    // correct unsigned magnitude.
    function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/mips_cpu_muldiv_iter.sv
// One-bit-per-cycle multiply/divide datapath: 64-bit accumulator holding
// {HI-side, LO-side} plus the iteration counter.
module mips_cpu_muldiv_iter
    import mips_cpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_load,
    input  logic        i_step,
    input  logic        i_is_div,
    input  logic [31:0] i_mag_a,
    input  logic [31:0] i_mag_b,
    output logic [63:0] o_acc,
    output logic        o_last
);

    localparam int unsigned CNT_W = $clog2(ITER_COUNT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(ITER_COUNT - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_is_div;
    logic [31:0]      r_opnd;
    logic [63:0]      r_acc;

    logic [32:0] w_sum;
    logic [32:0] w_rem_sh;
    logic [32:0] w_trial;
    logic [63:0] w_next;

    // Multiply: add multiplicand to upper half when LSB set, shift right.
    // Divide: shift {rem,quot} left, keep trial difference if no borrow.
    always_comb begin
        w_sum    = {1'b0, r_acc[63:32]} + {1'b0, r_opnd};
        w_rem_sh = r_acc[63:31];
        w_trial  = w_rem_sh - {1'b0, r_opnd};
        if (r_is_div) begin
            w_next = w_trial[32] ? {r_acc[62:0], 1'b0}
                                 : {w_trial[31:0], r_acc[30:0], 1'b1};
        end else begin
            w_next = r_acc[0] ? {w_sum, r_acc[31:1]} : {1'b0, r_acc[63:1]};
        end
    end

    // The lower half starts with the operand consumed bit by bit
    // (multiplier or dividend); r_opnd holds the one added/subtracted.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_opnd   <= '0;
            r_acc    <= '0;
        end else if (i_load) begin
            r_cnt    <= '0;
            r_is_div <= i_is_div;
            r_opnd   <= i_is_div ? i_mag_b : i_mag_a;
            r_acc    <= {32'd0, (i_is_div ? i_mag_a : i_mag_b)};
        end else if (i_step) begin
            r_acc <= w_next;
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_acc  = r_acc;
    assign o_last = (r_cnt == LAST);

endmodule

// File: rtl/mips_cpu_hilo_seq_unit.sv
// MIPS HI/LO register unit with iterative MULT/MULTU/DIV/DIVU, MTHI/MTLO
// writes and a registered MFHI/MFLO read port.
module mips_cpu_hilo_seq_unit
    import mips_cpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        mt_hi,
    input  logic        mt_lo,
    input  logic        rd_req,
    input  logic        rd_sel,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    output logic        busy,
    output logic        stall
);

    state_e      r_state;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_rd_data;
    logic        r_rd_valid;
    logic        r_busy;
    logic        r_is_div;
    logic        r_neg_lo;
    logic        r_neg_hi;
    logic        r_div0;
    logic [31:0] r_a_raw;

    op_e         w_op;
    logic        w_is_div;
    logic        w_signed;
    logic        w_load;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic [63:0] w_acc;
    logic        w_last;
    logic [63:0] w_prod;
    logic [31:0] w_quot;
    logic [31:0] w_rem;
    logic [31:0] w_fix_hi;
    logic [31:0] w_fix_lo;

    assign w_op     = op_e'(op);
    assign w_is_div = (w_op == OP_DIVU) || (w_op == OP_DIV);
    assign w_signed = (w_op == OP_DIV) || (w_op == OP_MULT);
    assign w_load   = (r_state == ST_IDLE) && start;
    assign w_mag_a  = mag32(a, w_signed);
    assign w_mag_b  = mag32(b, w_signed);

    mips_cpu_muldiv_iter u_iter (
        .clk      (clk),
        .reset    (reset),
        .i_load   (w_load),
        .i_step   (r_state == ST_RUN),
        .i_is_div (w_is_div),
        .i_mag_a  (w_mag_a),
        .i_mag_b  (w_mag_b),
        .o_acc    (w_acc),
        .o_last   (w_last)
    );

    // Sign correction applied once the unsigned magnitudes are done.
    always_comb begin
        w_prod = r_neg_lo ? (~w_acc + 64'd1) : w_acc;
        w_quot = r_neg_lo ? (~w_acc[31:0] + 32'd1) : w_acc[31:0];
        w_rem  = r_neg_hi ? (~w_acc[63:32] + 32'd1) : w_acc[63:32];
        if (!r_is_div) begin
            w_fix_hi = w_prod[63:32];
            w_fix_lo = w_prod[31:0];
        end else if (r_div0) begin
            w_fix_hi = r_a_raw;
            w_fix_lo = '1;
        end else begin
            w_fix_hi = w_rem;
            w_fix_lo = w_quot;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_hi       <= '0;
            r_lo       <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_is_div   <= 1'b0;
            r_neg_lo   <= 1'b0;
            r_neg_hi   <= 1'b0;
            r_div0     <= 1'b0;
            r_a_raw    <= '0;
        end else begin
            r_rd_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // Read samples the pre-write HI/LO when mt_* coincides.
                    if (mt_hi) r_hi <= a;
                    if (mt_lo) r_lo <= a;
                    if (rd_req) begin
                        r_rd_data  <= rd_sel ? r_lo : r_hi;
                        r_rd_valid <= 1'b1;
                    end
                    if (start) begin
                        r_is_div <= w_is_div;
                        r_neg_lo <= w_signed && (a[31] ^ b[31]);
                        r_neg_hi <= w_signed && a[31];
                        r_div0   <= (b == 32'd0);
                        r_a_raw  <= a;
                        r_busy   <= 1'b1;
                        r_state  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_last) r_state <= ST_FIX;
                end
                ST_FIX: begin
                    r_hi    <= w_fix_hi;
                    r_lo    <= w_fix_lo;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
    assign busy     = r_busy;
    assign stall    = (rd_req | mt_hi | mt_lo | start) & r_busy;

endmodule

// File: tb/tb_mips_cpu_hilo_seq_unit.sv
// Self-checking bench for mips_cpu_hilo_seq_unit against a plain-arithmetic
// HI/LO reference model.
module tb_mips_cpu_hilo_seq_unit;

    localparam logic [1:0] OPC_DIVU  = 2'b00;
    localparam logic [1:0] OPC_MULTU = 2'b01;
    localparam logic [1:0] OPC_DIV   = 2'b10;
    localparam logic [1:0] OPC_MULT  = 2'b11;

    logic        clk = 1'b0;
    logic        reset, start, mt_hi, mt_lo, rd_req, rd_sel;
    logic [1:0]  op;
    logic [31:0] a, b, rd_data;
    logic        rd_valid, busy, stall;

    int unsigned n_cmp = 0;
    int unsigned n_fail = 0;
    logic [31:0] m_hi, m_lo;

    always #5 clk = ~clk;

    mips_cpu_hilo_seq_unit dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .mt_hi(mt_hi), .mt_lo(mt_lo), .rd_req(rd_req), .rd_sel(rd_sel),
        .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .stall(stall)
    );

    // Returns {HI, LO} for an operation using native wide arithmetic.
    function automatic logic [63:0] ref_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] r;
        longint sx, sy, q, rm;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            OPC_MULTU: r = {32'd0, x} * {32'd0, y};
            OPC_MULT:  r = sx * sy;
            OPC_DIVU:  r = (y == 32'd0) ? {x, 32'hFFFFFFFF} : {x % y, x / y};
            default: begin
                if (y == 32'd0) r = {x, 32'hFFFFFFFF};
                else begin
                    q  = sx / sy;
                    rm = sx % sy;
                    r  = {rm[31:0], q[31:0]};
                end
            end
        endcase
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        start = 0; mt_hi = 0; mt_lo = 0; rd_req = 0; rd_sel = 0;
        op = 2'b00; a = '0; b = '0;
    endtask

    // Issues one op and waits (bounded) for busy to fall; cyc = busy cycles.
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          output int unsigned cyc);
        logic [63:0] r;
        op = o; a = x; b = y; start = 1;
        tick();
        start = 0;
        cyc = 0;
        while (busy && cyc < 100) begin
            cyc++;
            tick();
        end
        r = ref_op(o, x, y);
        m_hi = r[63:32];
        m_lo = r[31:0];
    endtask

    task automatic read_reg(input logic s, output logic v, output logic [31:0] d);
        rd_req = 1; rd_sel = s;
        tick();
        rd_req = 0;
        v = rd_valid;
        d = rd_data;
    endtask

    task automatic test_reset();
        logic v;
        logic [31:0] d;
        reset = 1;
        tick(); tick();
        reset = 0;
        m_hi = '0; m_lo = '0;
        n_cmp++;
        if (busy !== 1'b0 || rd_valid !== 1'b0 || rd_data !== 32'd0 || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: busy=%b rd_valid=%b rd_data=%h stall=%b, required 0/0/0/0",
                     busy, rd_valid, rd_data, stall);
        end
        for (int s = 0; s < 2; s++) begin
            read_reg(s[0], v, d);
            n_cmp++;
            if (v !== 1'b1 || d !== 32'd0) begin
                n_fail++;
                $display("FAIL reset_read sel=%0d: valid=%b data=%h, required 1/00000000", s, v, d);
            end
        end
    endtask

    task automatic test_spec_vectors();
        logic [1:0]  t_op [5] = '{OPC_MULTU, OPC_MULT, OPC_DIV, OPC_DIVU, OPC_DIV};
        logic [31:0] t_a  [5] = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFF9, 32'h7, 32'h80000000};
        logic [31:0] t_b  [5] = '{32'hFFFFFFFF, 32'h5, 32'h2, 32'h0, 32'hFFFFFFFF};
        logic [31:0] t_hi [5] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h7, 32'h0};
        logic [31:0] t_lo [5] = '{32'h00000001, 32'hFFFFFFF1, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000};
        int unsigned cyc;
        logic v;
        logic [31:0] d;
        for (int i = 0; i < 5; i++) begin
            run_op(t_op[i], t_a[i], t_b[i], cyc);
            n_cmp++;
            if (cyc != 33) begin
                n_fail++;
                $display("FAIL vec%0d_busy_cycles: got %0d, required 33", i, cyc);
            end
            read_reg(1'b0, v, d);
            n_cmp++;
            if (v !== 1'b1 || d !== t_hi[i]) begin
                n_fail++;
                $display("FAIL vec%0d_hi: valid=%b data=%h, required 1/%h", i, v, d, t_hi[i]);
            end
            read_reg(1'b1, v, d);
            n_cmp++;
            if (v !== 1'b1 || d !== t_lo[i]) begin
                n_fail++;
                $display("FAIL vec%0d_lo: valid=%b data=%h, required 1/%h", i, v, d, t_lo[i]);
            end
        end
    endtask

    task automatic test_stall_read();
        logic [31:0] x, y;
        logic [63:0] r;
        x = $urandom; y = $urandom_range(1, 1000);
        r = ref_op(OPC_DIVU, x, y);
        op = OPC_DIVU; a = x; b = y; start = 1;
        tick();                      // now in N+1
        start = 0;
        repeat (9) tick();           // now in N+10
        rd_req = 1; rd_sel = 1;
        #1;
        n_cmp++;
        if (stall !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_read_stall: stall=%b, required 1", stall);
        end
        tick();                      // N+11
        rd_req = 0;
        n_cmp++;
        if (rd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_read_valid: rd_valid=%b, required 0", rd_valid);
        end
        repeat (23) tick();          // N+34
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_end_n34: busy=%b, required 0", busy);
        end
        rd_req = 1; rd_sel = 1;
        tick();                      // N+35
        rd_req = 0;
        n_cmp++;
        if (rd_valid !== 1'b1 || rd_data !== r[31:0]) begin
            n_fail++;
            $display("FAIL reissued_read: valid=%b data=%h, required 1/%h", rd_valid, rd_data, r[31:0]);
        end
        m_hi = r[63:32]; m_lo = r[31:0];
    endtask

    task automatic test_reset_abort();
        int unsigned cyc;
        logic v;
        logic [31:0] d;
        mt_hi = 1; a = 32'h12345678;
        tick();
        mt_hi = 0;
        op = OPC_MULT; a = $urandom; b = $urandom; start = 1;
        tick();                      // N+1
        start = 0;
        repeat (14) tick();          // N+15
        reset = 1;
        tick();
        reset = 0;
        m_hi = '0; m_lo = '0;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_busy: busy=%b, required 0", busy);
        end
        read_reg(1'b0, v, d);
        n_cmp++;
        if (d !== 32'd0) begin
            n_fail++;
            $display("FAIL abort_hi: data=%h, required 00000000", d);
        end
        read_reg(1'b1, v, d);
        n_cmp++;
        if (d !== 32'd0) begin
            n_fail++;
            $display("FAIL abort_lo: data=%h, required 00000000", d);
        end
        run_op(OPC_MULT, 32'hFFFFFFF0, 32'h00000100, cyc);
        read_reg(1'b1, v, d);
        n_cmp++;
        if (cyc != 33 || d !== m_lo) begin
            n_fail++;
            $display("FAIL after_abort_op: cycles=%0d lo=%h, required 33/%h", cyc, d, m_lo);
        end
    endtask

    task automatic test_mt_read();
        logic [31:0] old_lo;
        logic v;
        logic [31:0] d;
        old_lo = m_lo;
        mt_lo = 1; a = 32'hA5A5A5A5; rd_req = 1; rd_sel = 1;
        tick();
        mt_lo = 0; rd_req = 0;
        m_lo = 32'hA5A5A5A5;
        n_cmp++;
        if (rd_valid !== 1'b1 || rd_data !== old_lo) begin
            n_fail++;
            $display("FAIL mt_read_same_cycle: valid=%b data=%h, required 1/%h", rd_valid, rd_data, old_lo);
        end
        a = 32'h0F0F0F0F;
        tick();
        n_cmp++;
        if (rd_valid !== 1'b0 || rd_data !== old_lo) begin
            n_fail++;
            $display("FAIL rd_data_hold: valid=%b data=%h, required 0/%h", rd_valid, rd_data, old_lo);
        end
        read_reg(1'b1, v, d);
        n_cmp++;
        if (v !== 1'b1 || d !== 32'hA5A5A5A5) begin
            n_fail++;
            $display("FAIL mt_read_next: valid=%b data=%h, required 1/a5a5a5a5", v, d);
        end
    endtask

    // start coinciding with MTHI/MTLO, and a second start while busy.
    task automatic test_back_to_back();
        logic [31:0] x, y;
        logic [63:0] r;
        int unsigned cyc;
        logic v;
        logic [31:0] d;
        x = $urandom; y = $urandom_range(1, 50000);
        r = ref_op(OPC_DIV, x, y);
        op = OPC_DIV; a = x; b = y; start = 1; mt_hi = 1; mt_lo = 1;
        tick();
        start = 0; mt_hi = 0; mt_lo = 0;
        repeat (4) tick();
        op = OPC_MULTU; a = $urandom; b = $urandom; start = 1;
        #1;
        n_cmp++;
        if (stall !== 1'b1) begin
            n_fail++;
            $display("FAIL start_while_busy_stall: stall=%b, required 1", stall);
        end
        tick();
        start = 0;
        cyc = 0;
        while (busy && cyc < 100) begin
            cyc++;
            tick();
        end
        m_hi = r[63:32]; m_lo = r[31:0];
        read_reg(1'b0, v, d);
        n_cmp++;
        if (cyc != 28 || d !== m_hi) begin
            n_fail++;
            $display("FAIL coincide_hi: remaining_busy=%0d hi=%h, required 28/%h", cyc, d, m_hi);
        end
        read_reg(1'b1, v, d);
        n_cmp++;
        if (d !== m_lo) begin
            n_fail++;
            $display("FAIL coincide_lo: lo=%h, required %h", d, m_lo);
        end
    endtask

    task automatic test_random();
        int unsigned cyc;
        int unsigned k;
        logic [31:0] x, y;
        logic v;
        logic [31:0] d;
        for (int i = 0; i < 60; i++) begin
            k = $urandom_range(0, 5);
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 7))
                0: y = 32'd0;
                1: begin x = 32'h80000000; y = 32'hFFFFFFFF; end
                2: y = $urandom_range(1, 16);
                3: y = -$urandom_range(1, 16);
                default: ;
            endcase
            if (k < 4) begin
                run_op(k[1:0], x, y, cyc);
                n_cmp++;
                if (cyc != 33) begin
                    n_fail++;
                    $display("FAIL rnd%0d_busy_cycles: got %0d, required 33", i, cyc);
                end
            end else begin
                a = x; mt_hi = (k == 4); mt_lo = (k == 5);
                tick();
                mt_hi = 0; mt_lo = 0;
                if (k == 4) m_hi = x; else m_lo = x;
            end
            read_reg(1'b0, v, d);
            n_cmp++;
            if (v !== 1'b1 || d !== m_hi) begin
                n_fail++;
                $display("FAIL rnd%0d_hi k=%0d a=%h b=%h: valid=%b data=%h, required 1/%h", i, k, x, y, v, d, m_hi);
            end
            read_reg(1'b1, v, d);
            n_cmp++;
            if (v !== 1'b1 || d !== m_lo) begin
                n_fail++;
                $display("FAIL rnd%0d_lo k=%0d a=%h b=%h: valid=%b data=%h, required 1/%h", i, k, x, y, v, d, m_lo);
            end
        end
    endtask

    initial begin
        clear_inputs();
        reset = 0;
        test_reset();
        test_spec_vectors();
        test_stall_read();
        test_reset_abort();
        test_mt_read();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
